vend_multi: RTL and testbench



---
 rtl/vend_pkg.sv | 37 +++
 rtl/vend_change_gen.sv | 27 ++
 rtl/vend_multi.sv | 180 ++++++++++++++++++
 tb/tb_vend_multi.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and defaults for the multi-product vending controller.
// The coin encoding matches the coin-acceptor front end directly.
package vend_pkg;

  typedef enum logic [1:0] {
    NC   = 2'b00,
    Y05  = 2'b01,
    Y1   = 2'b10,
    YINV = 2'b11
  } coin_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_COLLECT = 2'b01,
    S_VEND    = 2'b10,
    S_CHANGE  = 2'b11
  } state_t;

  localparam int DEF_N_PROD   = 4;
  localparam int DEF_CREDIT_W = 5;

  // Index 0 is the cheapest product; values are half-yuan units.
  localparam logic [DEF_N_PROD-1:0][DEF_CREDIT_W-1:0] DEF_PRICES =
    {5'd6, 5'd5, 5'd4, 5'd3};

  function automatic logic [1:0] coin_value(input coin_t c);
    logic [1:0] v;
    v = 2'd0;
    case (c)
      Y05:     v = 2'd1;
      Y1:      v = 2'd2;
      default: v = 2'd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/vend_change_gen.sv
// Change-step generator: for the remaining credit it picks the largest coin
// that fits, the remainder after ejecting it, and whether nothing is left.
module vend_change_gen
  import vend_pkg::*;
#(
  parameter int CREDIT_W = 5
) (
  input  logic [CREDIT_W-1:0] amount_i,
  output coin_t               coin_o,
  output logic [CREDIT_W-1:0] rest_o,
  output logic                done_o
);

  always_comb begin
    coin_o = NC;
    rest_o = amount_i;
    done_o = (amount_i == '0);
    if (amount_i >= CREDIT_W'(2)) begin
      coin_o = Y1;
      rest_o = amount_i - CREDIT_W'(2);
    end else if (amount_i == CREDIT_W'(1)) begin
      coin_o = Y05;
      rest_o = '0;
    end
  end

endmodule

// File: rtl/vend_multi.sv
// Multi-product vending controller: credit register, product selection,
// single-coin change ejection and cancel/refund. All outputs are registered.
module vend_multi
  import vend_pkg::*;
#(
  parameter int N_PROD     = 4,
  parameter int CREDIT_W   = 5,
  parameter int CREDIT_MAX = 15,
  parameter int SEL_W      = (N_PROD > 1) ? $clog2(N_PROD) : 1,
  parameter logic [N_PROD-1:0][CREDIT_W-1:0] PRICES = DEF_PRICES
) (
  input  logic                clk,
  input  logic                rst,
  // Strobes (pulse, sel_valid, cancel) are single-cycle requests with no
  // back-pressure; every refused request is answered by a one-cycle reject.
  input  logic                pulse,
  input  logic [1:0]          coin,
  input  logic                sel_valid,
  input  logic [SEL_W-1:0]    sel_id,
  input  logic                cancel,
  output logic                sell,
  output logic [SEL_W-1:0]    sell_id,
  output logic                change,
  output logic [1:0]          change_coin,
  output logic                coin_reject,
  output logic                sel_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output state_t              dbg_state_o
);

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                sell_q, sell_d;
  logic [SEL_W-1:0]    sell_id_q, sell_id_d;
  logic                change_q, change_d;
  logic [1:0]          change_coin_q, change_coin_d;
  logic                coin_rej_q, coin_rej_d;
  logic                sel_rej_q, sel_rej_d;
  logic                busy_q, busy_d;

  coin_t               coin_in;
  logic                coin_present;
  logic [CREDIT_W:0]   coin_sum;
  logic                sel_ok;
  logic [CREDIT_W-1:0] price;
  logic                sel_afford;

  coin_t               gen_coin;
  logic [CREDIT_W-1:0] gen_rest;
  logic                gen_done;

  assign coin_in      = coin_t'(coin);
  assign coin_present = pulse && (coin_in != NC);
  assign coin_sum     = {1'b0, credit_q} + (CREDIT_W+1)'(coin_value(coin_in));
  assign sel_ok       = (int'(sel_id) < N_PROD);
  assign price        = sel_ok ? PRICES[sel_id] : '0;
  assign sel_afford   = sel_ok && (credit_q >= price);

  // The generator always looks at the live credit, so the first change coin
  // can be issued on the same edge that enters CHANGE.
  vend_change_gen #(
    .CREDIT_W (CREDIT_W)
  ) u_change_gen (
    .amount_i (credit_q),
    .coin_o   (gen_coin),
    .rest_o   (gen_rest),
    .done_o   (gen_done)
  );

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    sell_d        = 1'b0;
    sell_id_d     = sell_id_q;
    change_d      = 1'b0;
    change_coin_d = 2'b00;
    coin_rej_d    = 1'b0;
    sel_rej_d     = 1'b0;

    unique case (state_q)
      S_IDLE, S_COLLECT: begin
        if (cancel && (state_q == S_COLLECT)) begin
          state_d       = S_CHANGE;
          change_d      = 1'b1;
          change_coin_d = gen_coin;
          credit_d      = gen_rest;
          coin_rej_d    = coin_present;
        end else if (sel_valid && sel_afford) begin
          state_d    = S_VEND;
          credit_d   = credit_q - price;
          sell_d     = 1'b1;
          sell_id_d  = sel_id;
          coin_rej_d = coin_present;
        end else begin
          sel_rej_d = sel_valid;
          if (pulse) begin
            if (coin_in == YINV) begin
              coin_rej_d = 1'b1;
            end else if (coin_in != NC) begin
              if (coin_sum <= (CREDIT_W+1)'(CREDIT_MAX)) begin
                credit_d = coin_sum[CREDIT_W-1:0];
                state_d  = S_COLLECT;
              end else begin
                coin_rej_d = 1'b1;
              end
            end
          end
        end
      end

      S_VEND: begin
        coin_rej_d = coin_present;
        sel_rej_d  = sel_valid;
        if (gen_done) begin
          state_d = S_IDLE;
        end else begin
          state_d       = S_CHANGE;
          change_d      = 1'b1;
          change_coin_d = gen_coin;
          credit_d      = gen_rest;
        end
      end

      S_CHANGE: begin
        coin_rej_d = coin_present;
        sel_rej_d  = sel_valid;
        if (gen_done) begin
          state_d = S_IDLE;
        end else begin
          change_d      = 1'b1;
          change_coin_d = gen_coin;
          credit_d      = gen_rest;
        end
      end

      default: begin
        state_d  = S_IDLE;
        credit_d = '0;
      end
    endcase

    busy_d = (state_d == S_VEND) || (state_d == S_CHANGE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      credit_q      <= '0;
      sell_q        <= 1'b0;
      sell_id_q     <= '0;
      change_q      <= 1'b0;
      change_coin_q <= 2'b00;
      coin_rej_q    <= 1'b0;
      sel_rej_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      sell_q        <= sell_d;
      sell_id_q     <= sell_id_d;
      change_q      <= change_d;
      change_coin_q <= change_coin_d;
      coin_rej_q    <= coin_rej_d;
      sel_rej_q     <= sel_rej_d;
      busy_q        <= busy_d;
    end
  end

  assign sell        = sell_q;
  assign sell_id     = sell_id_q;
  assign change      = change_q;
  assign change_coin = change_coin_q;
  assign coin_reject = coin_rej_q;
  assign sel_reject  = sel_rej_q;
  assign credit      = credit_q;
  assign busy        = busy_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_vend_multi.sv
// Bench for vend_multi: directed vectors, a transaction-level model that
// schedules per-cycle output frames, and hand-computed literal checks.
module tb_vend_multi;
  import vend_pkg::*;

  logic       clk;
  logic       rst;
  logic       pulse;
  logic [1:0] coin;
  logic       sel_valid;
  logic [1:0] sel_id;
  logic       cancel;
  logic       sell;
  logic [1:0] sell_id;
  logic       change;
  logic [1:0] change_coin;
  logic       coin_reject;
  logic       sel_reject;
  logic [4:0] credit;
  logic       busy;
  state_t     dbg_state;

  int checks = 0;
  int errors = 0;

  vend_multi dut (
    .clk         (clk),
    .rst         (rst),
    .pulse       (pulse),
    .coin        (coin),
    .sel_valid   (sel_valid),
    .sel_id      (sel_id),
    .cancel      (cancel),
    .sell        (sell),
    .sell_id     (sell_id),
    .change      (change),
    .change_coin (change_coin),
    .coin_reject (coin_reject),
    .sel_reject  (sel_reject),
    .credit      (credit),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model ----------------
  // Frame = {busy, sell, sell_id[1:0], change, change_coin[1:0], credit[4:0]}
  localparam int FW = 12;
  localparam int CMAX = 15;
  int price_tab [4] = '{3, 4, 5, 6};

  logic [FW-1:0] exp_q[$];
  logic [FW-1:0] cur_frame = '0;
  bit            m_started = 0;
  bit            m_busy    = 0;
  bit            m_crej    = 0;
  bit            m_srej    = 0;
  int            m_credit  = 0;
  logic [1:0]    m_id      = '0;

  function automatic logic [FW-1:0] frame(bit b, bit s, logic [1:0] id, bit ch,
                                          logic [1:0] cc, int cr);
    return {b, s, id, ch, cc, 5'(cr)};
  endfunction

  task automatic sched_change(int r);
    int c;
    while (r > 0) begin
      c = (r >= 2) ? 2 : 1;
      r = r - c;
      exp_q.push_back(frame(1'b1, 1'b0, m_id, 1'b1, 2'(c), r));
    end
    exp_q.push_back(frame(1'b0, 1'b0, m_id, 1'b0, 2'b00, 0));
  endtask

  always @(posedge clk) begin : model
    bit coin_in;
    int val;
    int r;
    m_started = 1;
    m_crej    = 0;
    m_srej    = 0;
    if (rst) begin
      exp_q.delete();
      m_credit  = 0;
      m_id      = '0;
      m_busy    = 0;
      cur_frame = '0;
    end else begin
      coin_in = pulse && (coin != 2'b00);
      if (m_busy) begin
        m_crej = coin_in;
        m_srej = sel_valid;
      end else if (cancel && m_credit > 0) begin
        m_crej = coin_in;
        sched_change(m_credit);
      end else if (sel_valid && m_credit >= price_tab[sel_id]) begin
        m_crej = coin_in;
        m_id   = sel_id;
        r      = m_credit - price_tab[sel_id];
        exp_q.push_back(frame(1'b1, 1'b1, m_id, 1'b0, 2'b00, r));
        sched_change(r);
      end else begin
        m_srej = sel_valid;
        if (pulse) begin
          val = (coin == 2'b01) ? 1 : (coin == 2'b10) ? 2 : 0;
          if (coin == 2'b11) m_crej = 1;
          else if (val > 0) begin
            if (m_credit + val <= CMAX) m_credit = m_credit + val;
            else m_crej = 1;
          end
        end
        exp_q.push_back(frame(1'b0, 1'b0, m_id, 1'b0, 2'b00, m_credit));
      end
      if (exp_q.size() > 0) cur_frame = exp_q.pop_front();
      else cur_frame = frame(1'b0, 1'b0, m_id, 1'b0, 2'b00, m_credit);
      m_credit = int'(cur_frame[4:0]);
      m_busy   = cur_frame[11];
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin : compare
    logic [FW+1:0] act;
    logic [FW+1:0] expv;
    if (m_started) begin
      act  = {busy, sell, sell_id, change, change_coin, credit, coin_reject, sel_reject};
      expv = {cur_frame, m_crej, m_srej};
      checks++;
      if (act !== expv) begin
        errors++;
        $display("FAIL cycle_outputs @%0t: got %b expected %b", $time, act, expv);
      end
    end
  end

  task automatic check_lit(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(bit p, logic [1:0] c, bit sv, logic [1:0] sid, bit cn);
    pulse     = p;
    coin      = c;
    sel_valid = sv;
    sel_id    = sid;
    cancel    = cn;
    @(negedge clk);
    pulse     = 1'b0;
    coin      = 2'b00;
    sel_valid = 1'b0;
    sel_id    = 2'b00;
    cancel    = 1'b0;
  endtask

  task automatic ins(logic [1:0] c);
    step(1'b1, c, 1'b0, 2'b00, 1'b0);
  endtask

  task automatic sel(logic [1:0] id);
    step(1'b0, 2'b00, 1'b1, id, 1'b0);
  endtask

  task automatic cxl();
    step(1'b0, 2'b00, 1'b0, 2'b00, 1'b1);
  endtask

  task automatic idle(int n);
    repeat (n) step(1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; pulse = 1'b0; coin = 2'b00; sel_valid = 1'b0; sel_id = 2'b00; cancel = 1'b0;
    @(negedge clk);
    check_lit("reset_credit", int'(credit), 0);
    check_lit("reset_busy", int'(busy), 0);
    check_lit("reset_state", int'(dbg_state), int'(S_IDLE));
    @(negedge clk);
    rst = 1'b0;

    // 1: exact payment, no change
    ins(2'b10); ins(2'b10);
    check_lit("t1_credit", int'(credit), 4);
    sel(2'd1);
    check_lit("t1_sell", int'(sell), 1);
    check_lit("t1_sell_id", int'(sell_id), 1);
    check_lit("t1_credit_after", int'(credit), 0);
    idle(1);
    check_lit("t1_idle_busy", int'(busy), 0);
    check_lit("t1_no_change", int'(change), 0);

    // 2: vend with 3 half-yuan change
    ins(2'b10); ins(2'b10); ins(2'b10);
    check_lit("t2_credit", int'(credit), 6);
    sel(2'd0);
    check_lit("t2_vend_credit", int'(credit), 3);
    idle(1);
    check_lit("t2_chg1_coin", int'(change_coin), 2);
    check_lit("t2_chg1_credit", int'(credit), 1);
    idle(1);
    check_lit("t2_chg2_coin", int'(change_coin), 1);
    check_lit("t2_chg2_credit", int'(credit), 0);
    idle(1);
    check_lit("t2_done_busy", int'(busy), 0);

    // 3: unaffordable selection then refund
    ins(2'b10);
    sel(2'd3);
    check_lit("t3_sel_reject", int'(sel_reject), 1);
    check_lit("t3_credit_kept", int'(credit), 2);
    cxl();
    check_lit("t3_refund_coin", int'(change_coin), 2);
    check_lit("t3_refund_credit", int'(credit), 0);
    idle(1);
    check_lit("t3_done_busy", int'(busy), 0);

    // 4: credit ceiling
    repeat (7) ins(2'b10);
    check_lit("t4_credit14", int'(credit), 14);
    ins(2'b10);
    check_lit("t4_reject_y1", int'(coin_reject), 1);
    check_lit("t4_credit_still14", int'(credit), 14);
    ins(2'b01);
    check_lit("t4_credit15", int'(credit), 15);
    ins(2'b01);
    check_lit("t4_reject_y05", int'(coin_reject), 1);
    cxl();
    check_lit("t4_refund_first", int'(credit), 13);
    idle(8);
    check_lit("t4_drained", int'(credit), 0);

    // 5: invalid coin, coin during CHANGE, simultaneous cancel/select/coin
    ins(2'b11);
    check_lit("t5_invalid_reject", int'(coin_reject), 1);
    ins(2'b10); ins(2'b10);
    sel(2'd0);
    idle(1);
    check_lit("t5_chg_coin", int'(change_coin), 1);
    ins(2'b10);
    check_lit("t5_busy_coin_reject", int'(coin_reject), 1);
    check_lit("t5_busy_coin_credit", int'(credit), 0);
    ins(2'b10); ins(2'b10);
    step(1'b1, 2'b01, 1'b1, 2'd0, 1'b1);
    check_lit("t5_combo_change", int'(change), 1);
    check_lit("t5_combo_credit", int'(credit), 2);
    check_lit("t5_combo_coin_reject", int'(coin_reject), 1);
    check_lit("t5_combo_no_sell", int'(sell), 0);
    idle(2);

    // 6: reset during CHANGE forfeits remaining change
    ins(2'b10); ins(2'b10); ins(2'b10);
    sel(2'd0);
    idle(1);
    check_lit("t6_in_change", int'(change), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_lit("t6_rst_change", int'(change), 0);
    check_lit("t6_rst_credit", int'(credit), 0);
    check_lit("t6_rst_state", int'(dbg_state), int'(S_IDLE));
    idle(1);
    check_lit("t6_after_change", int'(change), 0);

    // 7: every product from 8 half-yuan of credit
    for (int id = 0; id < 4; id++) begin
      repeat (4) ins(2'b10);
      sel(2'(id));
      check_lit("t7_vend_credit", int'(credit), 8 - (3 + id));
      idle(4);
    end

    idle(2);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
